// File: rtl/seq_pattern_generator.sv
// Bit-serial pattern transmitter: shifts a latched pattern out MSB-first, repeated.
// Optional inter-repetition zero gap is compiled in with SEQ_GEN_GAP_EN.
module seq_pattern_generator #(
  parameter int PAT_W   = 4,
  parameter int RPT_W   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [RPT_W-1:0] pat_rpt,
  input  logic             abort,
  output logic             seq,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_ON = (GAP_LEN != 0);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  logic [GW-1:0] r_gapcnt;
`else
  // Without the gap feature GAP_LEN has no effect on the stream.
  localparam bit GAP_ON = 1'b0 && (GAP_LEN != 0);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;
`endif

  state_t           r_state;
  logic [PAT_W-1:0] r_shift;
  logic [BW-1:0]    r_bitcnt;
  logic [RPT_W-1:0] r_rpt;
  logic             r_seq;
  logic             r_done;

  function automatic logic [PAT_W-1:0] rotl(
    input logic [PAT_W-1:0] v
  );
    return {v[PAT_W-2:0], v[PAT_W-1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_rpt    <= '0;
      r_seq    <= 1'b0;
      r_done   <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      r_gapcnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (pat_valid) begin
            r_state  <= ST_SHIFT;
            r_seq    <= pat_data[PAT_W-1];
            r_shift  <= rotl(pat_data);
            r_bitcnt <= '0;
            r_rpt    <= pat_rpt;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_seq   <= 1'b0;
          end else if (r_bitcnt == LAST_BIT) begin
            if (r_rpt == '0) begin
              r_state <= ST_IDLE;
              r_seq   <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rpt    <= r_rpt - 1'b1;
              r_bitcnt <= '0;
`ifdef SEQ_GEN_GAP_EN
              if (GAP_ON) begin
                r_state  <= ST_GAP;
                r_seq    <= 1'b0;
                r_gapcnt <= '0;
              end else begin
                r_seq   <= r_shift[PAT_W-1];
                r_shift <= rotl(r_shift);
              end
`else
              r_seq   <= r_shift[PAT_W-1];
              r_shift <= rotl(r_shift);
`endif
            end
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
            r_seq    <= r_shift[PAT_W-1];
            r_shift  <= rotl(r_shift);
          end
        end
`ifdef SEQ_GEN_GAP_EN
        ST_GAP: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_seq   <= 1'b0;
          end else if (r_gapcnt == GAP_LAST) begin
            r_state <= ST_SHIFT;
            r_seq   <= r_shift[PAT_W-1];
            r_shift <= rotl(r_shift);
          end else begin
            r_gapcnt <= r_gapcnt + 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_seq   <= 1'b0;
        end
      endcase
    end
  end

  assign pat_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign seq       = r_seq;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Self-checking bench for seq_pattern_generator (PAT_W=4, RPT_W=4, GAP_LEN=2).
// Table vectors, random streams vs a queue model, and abort/reset/back-to-back cases.
module tb_seq_pattern_generator;

  localparam int PAT_W   = 4;
  localparam int RPT_W   = 4;
  localparam int GAP_LEN = 2;
`ifdef SEQ_GEN_GAP_EN
  localparam int GAPS = GAP_LEN;
`else
  localparam int GAPS = 0;
`endif

  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  rpt;
    logic [63:0] bits;
    int          len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pat_valid = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pat_data = '0;
  logic [3:0] pat_rpt = '0;
  logic       pat_ready;
  logic       seq;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit obs[$];
  vec_t tbl[4];

  always #5 clk = ~clk;

  seq_pattern_generator #(
    .PAT_W(PAT_W),
    .RPT_W(RPT_W),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pat_valid(pat_valid),
    .pat_ready(pat_ready),
    .pat_data(pat_data),
    .pat_rpt(pat_rpt),
    .abort(abort),
    .seq(seq),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_seq"}, seq, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ready"}, pat_ready, 1);
  endtask

  // Expected stream: pattern MSB-first, rpt+1 times, zero gaps between.
  task automatic build(input logic [3:0] p, input int r);
    exp_q.delete();
    for (int t = 0; t <= r; t++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(p[b]);
      if (t < r)
        for (int g = 0; g < GAPS; g++) exp_q.push_back(1'b0);
    end
  endtask

  task automatic handshake(input logic [3:0] p, input logic [3:0] r);
    int n;
    n = 0;
    while (!pat_ready && n < 200) begin
      step();
      n++;
    end
    chk("ready_wait", pat_ready, 1);
    pat_valid = 1'b1;
    pat_data  = p;
    pat_rpt   = r;
    step();
    pat_valid = 1'b0;
    pat_data  = 4'($urandom);
    pat_rpt   = 4'($urandom);
  endtask

  // Called one cycle after the handshake edge; returns in the done cycle.
  task automatic check_stream();
    foreach (exp_q[i]) begin
      chk("seq_bit", seq, exp_q[i]);
      chk("busy_on", busy, 1);
      chk("done_early", done, 0);
      obs.push_back(seq);
      step();
    end
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("seq_end", seq, 0);
    chk("ready_end", pat_ready, 1);
  endtask

  initial begin
    logic [3:0] p;
    int r;
    int cnt;

    tbl[0] = '{4'b1011, 4'd0, 64'b1011, 4};
    tbl[3] = '{4'b0000, 4'd0, 64'b0000, 4};
`ifdef SEQ_GEN_GAP_EN
    tbl[1] = '{4'b0101, 4'd2, 64'b0101_00_0101_00_0101, 16};
    tbl[2] = '{4'b1011, 4'd1, 64'b1011_00_1011, 10};
`else
    tbl[1] = '{4'b0101, 4'd2, 64'b0101_0101_0101, 12};
    tbl[2] = '{4'b1011, 4'd1, 64'b1011_1011, 8};
`endif

    repeat (3) begin
      step();
      chk_idle("rst");
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk_idle("idle");
    end

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("idle_abort");

    foreach (tbl[k]) begin
      exp_q.delete();
      for (int i = tbl[k].len - 1; i >= 0; i--)
        exp_q.push_back(tbl[k].bits[i]);
      handshake(tbl[k].pat, tbl[k].rpt);
      check_stream();
      step();
      chk("tbl_done_once", done, 0);
    end

    build(4'b1100, 15);
    handshake(4'b1100, 4'hF);
    check_stream();
    step();
    chk("max_done_once", done, 0);

    repeat (16) begin
      p = 4'($urandom);
      r = $urandom_range(0, 3);
      build(p, r);
      handshake(p, 4'(r));
      check_stream();
      step();
      chk("rnd_done_once", done, 0);
      repeat ($urandom_range(0, 2)) step();
    end

    handshake(4'b1111, 4'd0);
    chk("ab_bit0", seq, 1);
    step();
    chk("ab_bit1", seq, 1);
    step();
    chk("ab_bit2", seq, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_mid");
    step();
    chk("abort_no_done", done, 0);

    handshake(4'b1111, 4'd0);
    repeat (3) step();
    chk("abl_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_last");
    step();
    chk("abort_last_no_done", done, 0);

    handshake(4'b1111, 4'd3);
    step();
    chk("ar_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    step();
    rst_n = 1'b1;
    chk_idle("rst_hold");
    step();
    chk_idle("rst_release");

    obs.delete();
    build(4'b1011, 0);
    handshake(4'b1011, 4'd0);
    check_stream();
    obs.push_back(seq);
    pat_valid = 1'b1;
    pat_data  = 4'b1001;
    pat_rpt   = 4'd0;
    step();
    pat_valid = 1'b0;
    build(4'b1001, 0);
    check_stream();
    cnt = 0;
    for (int i = 0; i + 3 < obs.size(); i++)
      if (obs[i] && !obs[i+1] && obs[i+2] && obs[i+3]) cnt++;
    chk("b2b_len", obs.size(), 9);
    chk("b2b_det_1011", cnt, 1);
    step();
    chk("b2b_done_once", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_generator.md
# seq_pattern_generator

- Bit-serial pattern transmitter: the driving end of the `seq` line consumed by the sequence detector.
- Accepts a PAT_W-bit pattern and a repeat count over a valid/ready handshake, then shifts the pattern out MSB-first, one bit per clock, the requested number of times.
- Sits upstream of the detector in self-checking and loopback setups, replacing hand-written `seq` stimulus.

## Interface
- PAT_W, 4, pattern width in bits (2..16)
- RPT_W, 4, repeat-count width
- GAP_LEN, 2, zero bits inserted between repetitions (used only with SEQ_GEN_GAP_EN)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pat_valid  input  1  pattern/count offered
- pat_ready  output  1  block can accept a pattern; high only in IDLE
- pat_data  input  PAT_W  pattern; bit PAT_W-1 is sent first
- pat_rpt  input  RPT_W  extra repetitions (transmissions = pat_rpt+1)
- abort  input  1  synchronous abort of transmission in progress
- seq  output  1  serial bit stream, registered
- busy  output  1  high while in SHIFT or GAP
- done  output  1  one-cycle pulse after the last bit of the last repetition

## Operation
- States:
  - IDLE: seq=0, pat_ready=1.
  - SHIFT: drives the pattern bits.
  - GAP: drives zero bits between repetitions; present only with the macro.
- Handshake: transfer when pat_valid && pat_ready at a rising edge.
  - Latch pat_data into the shift register and pat_rpt into the repeat counter.
  - Clear the bit counter; go to SHIFT.
  - pat_data and pat_rpt are ignored outside a transfer.
- SHIFT: seq = current shift-register MSB. Each cycle, rotate left by one and increment the bit counter (width clog2(PAT_W)).
  - After bit PAT_W-1 with repeat counter = 0: go to IDLE, pulse done.
  - After bit PAT_W-1 with repeat counter ≠ 0: decrement it, reload the bit counter, restore the pattern (the rotation returns it intact). Then go to GAP if the macro is defined, else continue SHIFT with no idle bit.
- GAP: seq=0 for exactly GAP_LEN cycles, then SHIFT. GAP_LEN=0 behaves as if the macro were undefined.
- abort while busy: next edge goes to IDLE, seq=0, busy=0, no done pulse. abort in IDLE has no effect. abort takes priority over the end-of-pattern transition in the same cycle.
- Back-to-back: pat_ready is high in the cycle done is high. A transfer in that cycle starts SHIFT on the next edge, so exactly one zero bit separates patterns.
- Repeat counter saturates at 0, with no wrap. pat_rpt = 2^RPT_W-1 yields 2^RPT_W transmissions.
- Reset mid-operation: immediately returns to IDLE and clears all counters; the partial pattern is discarded.
  - seq, busy and done go to 0 asynchronously.
  - pat_ready becomes 1 asynchronously.

## Timing
- Reset values: seq=0, busy=0, done=0, pat_ready=1.
- pat_ready and busy are decoded from the state register. seq and done are registered.
- Handshake at edge N: first bit on seq after edge N; bit k after edge N+k; busy=1 from edge N.
- Total busy cycles = (pat_rpt+1)·PAT_W, plus pat_rpt·GAP_LEN with the gap macro.
- done is high for the single cycle after the final bit. busy=0 in that same cycle.
- One bit per clock; no enable or stall input.

## Configuration
- SEQ_GEN_GAP_EN defined:
  - GAP state and gap counter are compiled in.
  - GAP_LEN zero bits are inserted between repetitions (not after the last one).
- SEQ_GEN_GAP_EN undefined:
  - No GAP state; repetitions are contiguous.
  - GAP_LEN is ignored.

## Test plan
- Reset/idle: hold rst_n=0 3 cycles, release with no pat_valid -> seq=0, busy=0, done=0, pat_ready=1 throughout.
- Single shot: PAT_W=4, pat_data=4'b1011, pat_rpt=0 -> seq = 1,0,1,1 on the 4 cycles after the handshake; done pulses in cycle 5; pat_ready returns high.
- Repeat, no macro: 4'b0101, pat_rpt=2 -> 12-cycle stream 010101010101; one done pulse.
- Repeat with SEQ_GEN_GAP_EN, GAP_LEN=2: 4'b1011, pat_rpt=1 -> 1011 00 1011; busy 10 cycles.
- Abort/reset mid-stream:
  - abort after bit 2 of 4'b1111 -> seq=0 next cycle, no done, pat_ready=1.
  - rst_n pulsed low mid-stream -> outputs reset immediately without waiting for a clock edge.
- Back-to-back: second transfer (4'b1001) in the done cycle of 4'b1011 -> stream 1011 0 1001; a detector looking for 1011 flags exactly once.
